// File: rtl/mesi_snoop_ctrl.sv
// Direct-mapped MESI cache controller with one outstanding CPU request,
// a single-master bus port, and a snoop port that updates line state every cycle.
module mesi_snoop_ctrl #(
  parameter logic [1:0] CPU_ID = 2'b01,
  parameter int         IDX_W  = 2,
  parameter int         TAG_W  = 3,
  parameter int         DATA_W = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cpu_req_valid,
  input  logic                    cpu_req_write,
  input  logic [TAG_W+IDX_W-1:0]  cpu_req_addr,
  input  logic [DATA_W-1:0]       cpu_req_wdata,
  output logic                    cpu_req_ready,
  output logic                    cpu_resp_valid,
  output logic [DATA_W-1:0]       cpu_resp_rdata,
  output logic                    bus_req,
  input  logic                    bus_gnt,
  output logic                    bus_out_valid,
  output logic [1:0]              bus_out_cmd,
  output logic [TAG_W+IDX_W-1:0]  bus_out_addr,
  input  logic                    bus_resp_valid,
  input  logic [DATA_W-1:0]       bus_resp_data,
  input  logic                    bus_resp_shared,
  input  logic                    snoop_valid,
  input  logic [1:0]              snoop_cmd,
  input  logic [1:0]              snoop_src,
  input  logic [TAG_W+IDX_W-1:0]  snoop_addr,
  output logic                    snoop_shared,
  output logic                    snoop_flush_valid,
  output logic [DATA_W-1:0]       snoop_flush_data,
  output logic                    wb_valid,
  output logic [TAG_W+IDX_W-1:0]  wb_addr,
  output logic [DATA_W-1:0]       wb_data
);

  localparam int N_LINES = 2 ** IDX_W;
  localparam int ADDR_W  = TAG_W + IDX_W;

  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_E = 2'b10;
  localparam logic [1:0] ST_M = 2'b11;

  localparam logic [1:0] CMD_RD   = 2'b01;
  localparam logic [1:0] CMD_RDX  = 2'b10;
  localparam logic [1:0] CMD_UPGR = 2'b11;

  typedef enum logic [1:0] {IDLE, ARB, WAIT_RESP} fsm_e;

  logic [1:0]        state_q [N_LINES];
  logic [TAG_W-1:0]  tag_q   [N_LINES];
  logic [DATA_W-1:0] data_q  [N_LINES];

  fsm_e              fsm_q;
  logic [1:0]        cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              cpu_resp_valid_q;
  logic [DATA_W-1:0] cpu_resp_rdata_q;
  logic              bus_out_valid_q;
  logic [1:0]        bus_out_cmd_q;
  logic [ADDR_W-1:0] bus_out_addr_q;
  logic              wb_valid_q;
  logic [ADDR_W-1:0] wb_addr_q;
  logic [DATA_W-1:0] wb_data_q;
  logic              flush_valid_q;
  logic [DATA_W-1:0] flush_data_q;

  logic [IDX_W-1:0]  cpu_idx, snp_idx, req_idx;
  logic [TAG_W-1:0]  cpu_tag, snp_tag, req_tag;
  logic              cpu_hit, snp_hit, snp_kills, snp_conflict, accept;
  logic [1:0]        snp_state, eff_cmd;

  logic              upd_en, upd_data_en;
  logic [IDX_W-1:0]  upd_idx;
  logic [1:0]        upd_state;
  logic [TAG_W-1:0]  upd_tag;
  logic [DATA_W-1:0] upd_data;

  assign cpu_idx = cpu_req_addr[IDX_W-1:0];
  assign cpu_tag = cpu_req_addr[ADDR_W-1:IDX_W];
  assign snp_idx = snoop_addr[IDX_W-1:0];
  assign snp_tag = snoop_addr[ADDR_W-1:IDX_W];
  assign req_idx = addr_q[IDX_W-1:0];
  assign req_tag = addr_q[ADDR_W-1:IDX_W];

  assign cpu_hit = (state_q[cpu_idx] != ST_I) && (tag_q[cpu_idx] == cpu_tag);
  assign snp_hit = snoop_valid && (snoop_src != CPU_ID) && (snoop_cmd != 2'b00) &&
                   (state_q[snp_idx] != ST_I) && (tag_q[snp_idx] == snp_tag);
  assign snp_kills = snp_hit && (snoop_cmd != CMD_RD);
  assign snp_state = (snoop_cmd == CMD_RD) ? ST_S : ST_I;

  // A foreign snoop on the same index owns the line this cycle; the CPU must retry.
  assign snp_conflict  = snoop_valid && (snoop_src != CPU_ID) && cpu_req_valid &&
                         (snp_idx == cpu_idx);
  assign cpu_req_ready = (fsm_q == IDLE) && !snp_conflict;
  assign accept        = cpu_req_valid && cpu_req_ready;

  // An upgrade whose S copy gets invalidated must fetch the line again.
  assign eff_cmd = ((cmd_q == CMD_UPGR) && snp_kills && (snp_idx == req_idx)) ? CMD_RDX : cmd_q;

  assign snoop_shared      = snp_hit && (snoop_cmd == CMD_RD);
  assign bus_req           = (fsm_q == ARB);
  assign cpu_resp_valid    = cpu_resp_valid_q;
  assign cpu_resp_rdata    = cpu_resp_rdata_q;
  assign bus_out_valid     = bus_out_valid_q;
  assign bus_out_cmd       = bus_out_cmd_q;
  assign bus_out_addr      = bus_out_addr_q;
  assign wb_valid          = wb_valid_q;
  assign wb_addr           = wb_addr_q;
  assign wb_data           = wb_data_q;
  assign snoop_flush_valid = flush_valid_q;
  assign snoop_flush_data  = flush_data_q;

  always_comb begin
    upd_en      = 1'b0;
    upd_data_en = 1'b0;
    upd_idx     = req_idx;
    upd_state   = ST_I;
    upd_tag     = req_tag;
    upd_data    = wdata_q;
    case (fsm_q)
      IDLE: begin
        if (accept) begin
          upd_idx = cpu_idx;
          upd_tag = tag_q[cpu_idx];
          if (!cpu_hit) begin
            upd_en    = 1'b1;
            upd_state = ST_I;
          end else if (cpu_req_write && (state_q[cpu_idx] != ST_S)) begin
            upd_en      = 1'b1;
            upd_state   = ST_M;
            upd_data_en = 1'b1;
            upd_data    = cpu_req_wdata;
          end
        end
      end
      ARB: begin
        if (bus_gnt && (eff_cmd == CMD_UPGR)) begin
          upd_en      = 1'b1;
          upd_state   = ST_M;
          upd_data_en = 1'b1;
        end
      end
      WAIT_RESP: begin
        if (bus_resp_valid) begin
          upd_en      = 1'b1;
          upd_data_en = 1'b1;
          if (cmd_q == CMD_RD) begin
            upd_state = bus_resp_shared ? ST_S : ST_E;
            upd_data  = bus_resp_data;
          end else begin
            upd_state = ST_M;
          end
        end
      end
      default: ;
    endcase
  end

  // Line array: own-request updates are applied after snoop updates.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_LINES; i++) begin
        state_q[i] <= ST_I;
        tag_q[i]   <= '0;
        data_q[i]  <= '0;
      end
    end else begin
      if (snp_hit) state_q[snp_idx] <= snp_state;
      if (upd_en) begin
        state_q[upd_idx] <= upd_state;
        tag_q[upd_idx]   <= upd_tag;
        if (upd_data_en) data_q[upd_idx] <= upd_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_q            <= IDLE;
      cmd_q            <= 2'b00;
      addr_q           <= '0;
      wdata_q          <= '0;
      cpu_resp_valid_q <= 1'b0;
      cpu_resp_rdata_q <= '0;
      bus_out_valid_q  <= 1'b0;
      bus_out_cmd_q    <= 2'b00;
      bus_out_addr_q   <= '0;
      wb_valid_q       <= 1'b0;
      wb_addr_q        <= '0;
      wb_data_q        <= '0;
      flush_valid_q    <= 1'b0;
      flush_data_q     <= '0;
    end else begin
      cpu_resp_valid_q <= 1'b0;
      bus_out_valid_q  <= 1'b0;
      wb_valid_q       <= 1'b0;
      flush_valid_q    <= snp_hit && (state_q[snp_idx] == ST_M) && (snoop_cmd != CMD_UPGR);
      flush_data_q     <= data_q[snp_idx];
      case (fsm_q)
        IDLE: begin
          if (accept) begin
            addr_q  <= cpu_req_addr;
            wdata_q <= cpu_req_wdata;
            if (cpu_hit && !cpu_req_write) begin
              cpu_resp_valid_q <= 1'b1;
              cpu_resp_rdata_q <= data_q[cpu_idx];
            end else if (cpu_hit && (state_q[cpu_idx] != ST_S)) begin
              cpu_resp_valid_q <= 1'b1;
              cpu_resp_rdata_q <= cpu_req_wdata;
            end else if (cpu_hit) begin
              fsm_q <= ARB;
              cmd_q <= CMD_UPGR;
            end else begin
              fsm_q <= ARB;
              cmd_q <= cpu_req_write ? CMD_RDX : CMD_RD;
              if (state_q[cpu_idx] == ST_M) begin
                wb_valid_q <= 1'b1;
                wb_addr_q  <= {tag_q[cpu_idx], cpu_idx};
                wb_data_q  <= data_q[cpu_idx];
              end
            end
          end
        end
        ARB: begin
          cmd_q <= eff_cmd;
          if (bus_gnt) begin
            bus_out_valid_q <= 1'b1;
            bus_out_cmd_q   <= eff_cmd;
            bus_out_addr_q  <= addr_q;
            if (eff_cmd == CMD_UPGR) begin
              cpu_resp_valid_q <= 1'b1;
              cpu_resp_rdata_q <= wdata_q;
              fsm_q            <= IDLE;
            end else begin
              fsm_q <= WAIT_RESP;
            end
          end
        end
        WAIT_RESP: begin
          if (bus_resp_valid) begin
            cpu_resp_valid_q <= 1'b1;
            cpu_resp_rdata_q <= (cmd_q == CMD_RD) ? bus_resp_data : wdata_q;
            fsm_q            <= IDLE;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mesi_snoop_ctrl.sv
// Directed bench for mesi_snoop_ctrl; CPU responses are checked against a queue of expected data.
module tb_mesi_snoop_ctrl;
  localparam logic [1:0] RD = 2'b01, RDX = 2'b10, UPGR = 2'b11;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cpu_req_valid = 1'b0, cpu_req_write = 1'b0;
  logic [4:0] cpu_req_addr = '0;
  logic [7:0] cpu_req_wdata = '0;
  logic       cpu_req_ready, cpu_resp_valid;
  logic [7:0] cpu_resp_rdata;
  logic       bus_req, bus_gnt = 1'b0, bus_out_valid;
  logic [1:0] bus_out_cmd;
  logic [4:0] bus_out_addr;
  logic       bus_resp_valid = 1'b0, bus_resp_shared = 1'b0;
  logic [7:0] bus_resp_data = '0;
  logic       snoop_valid = 1'b0;
  logic [1:0] snoop_cmd = '0, snoop_src = '0;
  logic [4:0] snoop_addr = '0;
  logic       snoop_shared, snoop_flush_valid, wb_valid;
  logic [7:0] snoop_flush_data, wb_data;
  logic [4:0] wb_addr;

  mesi_snoop_ctrl dut (
    .clock(clock), .reset(reset),
    .cpu_req_valid(cpu_req_valid), .cpu_req_write(cpu_req_write),
    .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
    .cpu_req_ready(cpu_req_ready), .cpu_resp_valid(cpu_resp_valid),
    .cpu_resp_rdata(cpu_resp_rdata),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_out_valid(bus_out_valid),
    .bus_out_cmd(bus_out_cmd), .bus_out_addr(bus_out_addr),
    .bus_resp_valid(bus_resp_valid), .bus_resp_data(bus_resp_data),
    .bus_resp_shared(bus_resp_shared),
    .snoop_valid(snoop_valid), .snoop_cmd(snoop_cmd), .snoop_src(snoop_src),
    .snoop_addr(snoop_addr), .snoop_shared(snoop_shared),
    .snoop_flush_valid(snoop_flush_valid), .snoop_flush_data(snoop_flush_data),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clock = ~clock;

  int total = 0, bad = 0, n_resp = 0, n_push = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    exp_q.push_back(d);
    n_push++;
  endtask

  always @(negedge clock) begin
    if (!reset && cpu_resp_valid) begin
      logic [7:0] e;
      n_resp++;
      if (exp_q.size() == 0) begin
        chk("resp_unexpected", 32'(cpu_resp_rdata), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("resp_data", 32'(cpu_resp_rdata), 32'(e));
      end
    end
  end

  task automatic cpu_go(input bit w, input logic [4:0] a, input logic [7:0] d);
    cpu_req_valid = 1'b1; cpu_req_write = w; cpu_req_addr = a; cpu_req_wdata = d;
    #1 chk("cpu_ready", 32'(cpu_req_ready), 1);
    @(negedge clock);
    cpu_req_valid = 1'b0;
  endtask

  task automatic snoop_go(input logic [1:0] c, input logic [1:0] s, input logic [4:0] a,
                          input bit exp_shared);
    snoop_valid = 1'b1; snoop_cmd = c; snoop_src = s; snoop_addr = a;
    #1 chk("snoop_shared", 32'(snoop_shared), 32'(exp_shared));
    @(negedge clock);
    snoop_valid = 1'b0;
  endtask

  task automatic bus_xact(input logic [1:0] c, input logic [4:0] a, input int dly,
                          input bit do_resp, input logic [7:0] d, input bit sh,
                          input logic [7:0] exp_rd);
    for (int i = 0; i < dly; i++) begin
      chk("bus_req_hold", 32'(bus_req), 1);
      @(negedge clock);
    end
    chk("bus_req", 32'(bus_req), 1);
    if (c == UPGR) push(exp_rd);
    bus_gnt = 1'b1;
    @(negedge clock);
    bus_gnt = 1'b0;
    chk("bus_out_valid", 32'(bus_out_valid), 1);
    chk("bus_out_cmd", 32'(bus_out_cmd), 32'(c));
    chk("bus_out_addr", 32'(bus_out_addr), 32'(a));
    chk("bus_req_drop", 32'(bus_req), 0);
    if (c != UPGR) begin
      @(negedge clock);
      chk("bus_out_pulse", 32'(bus_out_valid), 0);
      if (do_resp) begin
        push(exp_rd);
        bus_resp_valid = 1'b1; bus_resp_data = d; bus_resp_shared = sh;
        @(negedge clock);
        bus_resp_valid = 1'b0; bus_resp_shared = 1'b0;
      end
    end
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_resp", 32'(cpu_resp_valid), 0);
    chk("rst_bus_req", 32'(bus_req), 0);
    chk("rst_bus_out", 32'(bus_out_valid), 0);
    chk("rst_wb", 32'(wb_valid), 0);
    chk("rst_flush", 32'(snoop_flush_valid), 0);
    chk("rst_line1", 32'(dut.state_q[1]), 0);
    reset = 1'b0;
    #1 chk("rst_ready", 32'(cpu_req_ready), 1);
    @(negedge clock);

    // Cold read miss filled exclusive
    cpu_go(1'b0, 5'b01001, 8'h00);
    chk("miss_no_wb", 32'(wb_valid), 0);
    bus_xact(RD, 5'b01001, 1, 1'b1, 8'hA5, 1'b0, 8'hA5);
    chk("line_E", 32'(dut.state_q[1]), 32'(2'b10));

    // Silent E->M write, then foreign read forces flush and S
    push(8'h3C);
    cpu_go(1'b1, 5'b01001, 8'h3C);
    chk("wr_hit_no_bus", 32'(bus_req), 0);
    chk("line_M", 32'(dut.state_q[1]), 32'(2'b11));
    snoop_go(RD, 2'b10, 5'b01001, 1'b1);
    chk("flush_valid", 32'(snoop_flush_valid), 1);
    chk("flush_data", 32'(snoop_flush_data), 32'h3C);
    chk("line_S", 32'(dut.state_q[1]), 32'(2'b01));
    @(negedge clock);
    chk("flush_pulse", 32'(snoop_flush_valid), 0);

    // Upgrade turned into RDX by a foreign upgrade before grant
    cpu_go(1'b1, 5'b01001, 8'h77);
    chk("upgr_arb", 32'(bus_req), 1);
    snoop_go(UPGR, 2'b11, 5'b01001, 1'b0);
    chk("upgr_inval", 32'(dut.state_q[1]), 0);
    chk("upgr_no_flush", 32'(snoop_flush_valid), 0);
    bus_xact(RDX, 5'b01001, 0, 1'b1, 8'hEE, 1'b0, 8'h77);
    chk("rdx_M", 32'(dut.state_q[1]), 32'(2'b11));
    chk("rdx_data", 32'(dut.data_q[1]), 32'h77);

    // Dirty victim writeback ahead of the conflicting read
    push(8'h3C);
    cpu_go(1'b1, 5'b01001, 8'h3C);
    cpu_go(1'b0, 5'b11101, 8'h00);
    chk("wb_valid", 32'(wb_valid), 1);
    chk("wb_addr", 32'(wb_addr), 32'(5'b01001));
    chk("wb_data", 32'(wb_data), 32'h3C);
    bus_xact(RD, 5'b11101, 0, 1'b1, 8'hB2, 1'b1, 8'hB2);
    chk("wb_pulse", 32'(wb_valid), 0);
    chk("shared_fill_S", 32'(dut.state_q[1]), 32'(2'b01));

    // Snoop and CPU collide on one index: snoop wins, retry misses
    cpu_req_valid = 1'b1; cpu_req_write = 1'b1; cpu_req_addr = 5'b11101; cpu_req_wdata = 8'h55;
    snoop_valid = 1'b1; snoop_cmd = RDX; snoop_src = 2'b10; snoop_addr = 5'b11101;
    #1 chk("conflict_ready", 32'(cpu_req_ready), 0);
    @(negedge clock);
    cpu_req_valid = 1'b0; snoop_valid = 1'b0;
    chk("conflict_inval", 32'(dut.state_q[1]), 0);
    chk("conflict_idle", 32'(bus_req), 0);
    cpu_go(1'b1, 5'b11101, 8'h55);
    chk("retry_no_wb", 32'(wb_valid), 0);
    bus_xact(RDX, 5'b11101, 1, 1'b1, 8'h00, 1'b0, 8'h55);
    push(8'h55);
    cpu_go(1'b0, 5'b11101, 8'h00);
    chk("rd_hit_no_bus", 32'(bus_req), 0);

    // Own-source and tag-miss snoops are ignored
    snoop_go(RD, 2'b01, 5'b11101, 1'b0);
    chk("own_snoop_no_flush", 32'(snoop_flush_valid), 0);
    snoop_go(RD, 2'b10, 5'b01101, 1'b0);
    chk("miss_snoop_keep_M", 32'(dut.state_q[1]), 32'(2'b11));

    // Plain upgrade on grant
    cpu_go(1'b0, 5'b00011, 8'h00);
    bus_xact(RD, 5'b00011, 0, 1'b1, 8'h19, 1'b1, 8'h19);
    cpu_go(1'b1, 5'b00011, 8'h66);
    bus_xact(UPGR, 5'b00011, 2, 1'b0, 8'h00, 1'b0, 8'h66);
    chk("upgr_M", 32'(dut.state_q[3]), 32'(2'b11));
    chk("upgr_data", 32'(dut.data_q[3]), 32'h66);

    // Reset while waiting for the bus response
    cpu_go(1'b0, 5'b00010, 8'h00);
    bus_xact(RD, 5'b00010, 0, 1'b0, 8'h00, 1'b0, 8'h00);
    reset = 1'b1;
    bus_resp_valid = 1'b1; bus_resp_data = 8'h99;
    @(negedge clock);
    reset = 1'b0; bus_resp_valid = 1'b0;
    chk("rr_bus_req", 32'(bus_req), 0);
    chk("rr_resp", 32'(cpu_resp_valid), 0);
    chk("rr_wb", 32'(wb_valid), 0);
    chk("rr_line2", 32'(dut.state_q[2]), 0);
    chk("rr_line3", 32'(dut.state_q[3]), 0);
    #1 chk("rr_ready", 32'(cpu_req_ready), 1);
    @(negedge clock);
    chk("rr_resp_later", 32'(cpu_resp_valid), 0);

    #1;
    chk("queue_empty", 32'(exp_q.size()), 0);
    chk("resp_count", 32'(n_resp), 32'(n_push));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mesi_snoop_ctrl.md
MESI_SNOOP_CTRL -- requirements
Module: mesi_snoop_ctrl

Interface
REQ-001 SHALL have parameter CPU_ID, default 2'b01: bus source code of this node.
REQ-002 SHALL have parameter IDX_W, default 2: line index width; N_LINES = 2**IDX_W, direct-mapped.
REQ-003 SHALL have parameter TAG_W, default 3: tag width; ADDR_W = TAG_W+IDX_W, addr = {tag,index}.
REQ-004 SHALL have parameter DATA_W, default 8: data word width, one word per line.
REQ-005 SHALL have ports: clock  in  1  single clock, all logic on posedge; reset  in  1  synchronous, active-high.
REQ-006 SHALL have CPU ports: cpu_req_valid in 1; cpu_req_write in 1 (0 read, 1 write); cpu_req_addr in ADDR_W; cpu_req_wdata in DATA_W; cpu_req_ready out 1; cpu_resp_valid out 1; cpu_resp_rdata out DATA_W.
REQ-007 SHALL have bus-master ports: bus_req out 1; bus_gnt in 1; bus_out_valid out 1; bus_out_cmd out 2 (01 BUS_RD, 10 BUS_RDX, 11 BUS_UPGR); bus_out_addr out ADDR_W; bus_resp_valid in 1; bus_resp_data in DATA_W; bus_resp_shared in 1.
REQ-008 SHALL have snoop ports: snoop_valid in 1; snoop_cmd in 2; snoop_src in 2; snoop_addr in ADDR_W; snoop_shared out 1; snoop_flush_valid out 1; snoop_flush_data out DATA_W.
REQ-009 SHALL have writeback ports: wb_valid out 1; wb_addr out ADDR_W; wb_data out DATA_W.

Function
REQ-010 Each line SHALL hold state (00 I, 01 S, 10 E, 11 M), tag, data; hit = state!=I and tag match.
REQ-011 Controller FSM SHALL have states IDLE, ARB, WAIT_RESP; cpu_req_ready=1 only in IDLE.
REQ-012 IDLE read hit SHALL give cpu_resp_valid for 1 cycle, next cycle, with line data; line state unchanged.
REQ-013 IDLE write hit in E or M SHALL write data, set M, respond next cycle (rdata = written value).
REQ-014 IDLE write hit in S SHALL go to ARB with cmd BUS_UPGR.
REQ-015 IDLE miss SHALL go to ARB with BUS_RD (read) or BUS_RDX (write); if victim is M, wb_valid pulses 1 cycle next cycle with {victim tag,index} and victim data; victim line set I on acceptance.
REQ-016 ARB: bus_req=1 until bus_gnt sampled high; on grant, bus_out_valid=1 for exactly 1 cycle with cmd and request addr, bus_req drops same cycle.
REQ-017 BUS_UPGR on grant: line -> M, data written, respond next cycle, back to IDLE.
REQ-018 If snoop invalidates the pending S line while in ARB before grant, pending cmd SHALL become BUS_RDX.
REQ-019 WAIT_RESP on bus_resp_valid: BUS_RD fills line, state S if bus_resp_shared else E, rdata = bus_resp_data; BUS_RDX fills, merges write data, state M; respond next cycle, IDLE.
REQ-020 Snoops with snoop_src==CPU_ID, or missing the line, SHALL be ignored.
REQ-021 Snoop BUS_RD hit: snoop_shared=1 combinationally same cycle; M -> S with snoop_flush_valid=1 next cycle carrying line data; E -> S; S stays S.
REQ-022 Snoop BUS_RDX hit: M -> I with flush as REQ-021; E,S -> I. Snoop BUS_UPGR hit: -> I, no flush.
REQ-023 Snoop and CPU request same cycle on same index: cpu_req_ready SHALL be 0 that cycle; snoop wins, CPU retries.
REQ-024 Snoop state updates SHALL be applied in every FSM state; pending line is I during WAIT_RESP so snoops to it miss.
REQ-025 All pulses (cpu_resp_valid, bus_out_valid, wb_valid, snoop_flush_valid) SHALL be exactly 1 cycle.

Reset
REQ-026 reset high at posedge: all lines I, tags 0, data 0, FSM IDLE, all outputs 0 except cpu_req_ready=1 once released.
REQ-027 Reset mid-transaction SHALL abandon it: bus_req low next cycle, no response, no writeback.

Verification
REQ-028 Read 5'b01001 cold -> bus_req, grant, BUS_RD addr 01001; resp data 8'hA5 shared=0 -> rdata A5, line E.
REQ-029 Write 8'h3C to same addr (E) -> resp next cycle, no bus activity, line M; snoop BUS_RD from src 2'b10 -> snoop_shared=1, flush 3C next cycle, line S.
REQ-030 Write 8'h77 to S line, hold bus_gnt low, snoop BUS_UPGR same addr from src 2'b11 -> bus_out_cmd BUS_RDX after grant, final line M data 77.
REQ-031 Line idx 1 M data 3C tag 010; read addr 11101 -> wb_valid addr 01001 data 3C, then BUS_RD 11101.
REQ-032 Snoop BUS_RDX and CPU write to same index same cycle -> cpu_req_ready=0, line I, CPU retry later misses; reset during WAIT_RESP -> IDLE, no resp.
